// File: rtl/button_poll_master_if.sv
// Avalon-MM master bus used by the button poller to reach a PIO-style button slave.
interface button_poll_master_if;
    logic [3:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/button_poll_master.sv
// Periodically polls a PIO button slave: reads and clears its edge-capture register,
// samples the data register, and reports captured edges as pulses and a running count.
module button_poll_master #(
    parameter int WIDTH       = 2,
    parameter int POLL_PERIOD = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    button_poll_master_if.master avm,
    output logic [WIDTH-1:0]     event_pulse,
    output logic [WIDTH-1:0]     button_level,
    output logic [15:0]          event_count,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_EDGE,
        WR_CLR,
        RD_DATA,
        REPORT
    } state_t;

    localparam logic [23:0] RELOAD    = 24'(POLL_PERIOD - 1);
    localparam logic [3:0]  ADDR_DATA = 4'h0;
    localparam logic [3:0]  ADDR_EDGE = 4'hC;

    state_t             r_state;
    logic [23:0]        r_timer;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_level;
    logic [WIDTH-1:0]   r_pulse;
    logic [15:0]        r_count;
    logic [3:0]         r_addr;
    logic               r_rd;
    logic               r_wr;
    logic [31:0]        r_wdata;
    logic [WIDTH-1:0]   w_rd_bits;
    logic               w_rd_unused;

    assign w_rd_bits   = avm.avm_readdata[WIDTH-1:0];
    assign w_rd_unused = ^avm.avm_readdata;

    function automatic logic [15:0] popcount(input logic [WIDTH-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + 16'(v[i]);
        end
        return n;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= RELOAD;
            r_mask  <= '0;
            r_level <= '0;
            r_pulse <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else begin
            // Timer keeps running through a poll so starts stay POLL_PERIOD apart;
            // if a slow poll overruns, it parks at 0 and the next poll starts on return to IDLE.
            if (r_state == IDLE && !enable) begin
                r_timer <= RELOAD;
            end else if (r_timer == '0) begin
                if (r_state == IDLE) begin
                    r_timer <= RELOAD;
                end
            end else begin
                r_timer <= r_timer - 24'd1;
            end

            r_pulse <= '0;

            case (r_state)
                IDLE: begin
                    if (enable && r_timer == '0) begin
                        r_state <= RD_EDGE;
                        r_rd    <= 1'b1;
                        r_addr  <= ADDR_EDGE;
                    end
                end
                RD_EDGE: begin
                    if (!avm.avm_waitrequest) begin
                        r_mask <= w_rd_bits;
                        if (|w_rd_bits) begin
                            r_state <= WR_CLR;
                            r_rd    <= 1'b0;
                            r_wr    <= 1'b1;
                            r_addr  <= ADDR_EDGE;
                            r_wdata <= 32'(w_rd_bits);
                        end else begin
                            r_state <= RD_DATA;
                            r_addr  <= ADDR_DATA;
                        end
                    end
                end
                WR_CLR: begin
                    // Only the bits seen by the edge read are cleared, so newer edges survive.
                    if (!avm.avm_waitrequest) begin
                        r_state <= RD_DATA;
                        r_wr    <= 1'b0;
                        r_wdata <= '0;
                        r_rd    <= 1'b1;
                        r_addr  <= ADDR_DATA;
                    end
                end
                RD_DATA: begin
                    if (!avm.avm_waitrequest) begin
                        r_state <= REPORT;
                        r_rd    <= 1'b0;
                        r_addr  <= '0;
                        r_level <= w_rd_bits;
                        r_pulse <= r_mask;
                        r_count <= r_count + popcount(r_mask);
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                    r_addr  <= '0;
                    r_wdata <= '0;
                end
            endcase
        end
    end

    assign avm.avm_address   = r_addr;
    assign avm.avm_read      = r_rd;
    assign avm.avm_write     = r_wr;
    assign avm.avm_writedata = r_wdata;
    assign event_pulse       = r_pulse;
    assign button_level      = r_level;
    assign event_count       = r_count;
    assign busy              = (r_state != IDLE);

endmodule

// File: doc/button_poll_master.md
BUTTON_POLL_MASTER -- requirements
Module: button_poll_master

Interface
REQ-001 SHALL have parameter WIDTH, default 2: number of button bits polled.
REQ-002 SHALL have parameter POLL_PERIOD, default 50000: clk cycles between poll starts (1 ms at 50 MHz), legal range 4..2^24-1.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: polling permitted when high.
REQ-006 SHALL have port avm_address, output, 4: byte address (data reg = 0x0, edge-capture reg = 0xC).
REQ-007 SHALL have port avm_read, output, 1: Avalon-MM read request.
REQ-008 SHALL have port avm_write, output, 1: Avalon-MM write request.
REQ-009 SHALL have port avm_writedata, output, 32: write data.
REQ-010 SHALL have port avm_readdata, input, 32: read data, valid in the cycle where avm_read=1 and avm_waitrequest=0.
REQ-011 SHALL have port avm_waitrequest, input, 1: slave stall.
REQ-012 SHALL have port event_pulse, output, WIDTH: one-cycle pulse per captured button edge.
REQ-013 SHALL have port button_level, output, WIDTH: last sampled button data register.
REQ-014 SHALL have port event_count, output, 16: total captured edges, wraps at 0xFFFF->0x0000.
REQ-015 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, RD_EDGE, WR_CLR, RD_DATA, REPORT.
REQ-017 Poll timer SHALL count down from POLL_PERIOD-1 in IDLE while enable=1; on reaching 0, it reloads and the FSM enters RD_EDGE.
REQ-018 enable=0 SHALL hold the timer at POLL_PERIOD-1 in IDLE; a transaction already in progress SHALL complete.
REQ-019 RD_EDGE SHALL drive avm_read=1, avm_address=0xC until avm_waitrequest=0, then latch mask = avm_readdata[WIDTH-1:0].
REQ-020 mask nonzero: next state WR_CLR; mask zero: next state RD_DATA (no clear write).
REQ-021 WR_CLR SHALL drive avm_write=1, avm_address=0xC, avm_writedata = zero-extended mask until avm_waitrequest=0, then go to RD_DATA.
REQ-022 RD_DATA SHALL drive avm_read=1, avm_address=0x0 until avm_waitrequest=0, then load button_level = avm_readdata[WIDTH-1:0] and go to REPORT.
REQ-023 REPORT SHALL last exactly one cycle: event_pulse = mask (zero if mask zero), event_count += popcount(mask) modulo 2^16, then IDLE.
REQ-024 event_pulse SHALL be 0 in every cycle other than REPORT.
REQ-025 avm_read and avm_write SHALL never both be high; address and writedata SHALL be held stable while waitrequest=1.
REQ-026 In IDLE and REPORT, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0.
REQ-027 With zero waitrequest, one poll SHALL take 3 cycles (mask zero) or 4 cycles (mask nonzero) from leaving IDLE to returning.
REQ-028 A button edge arriving at the slave after the RD_EDGE read SHALL NOT be cleared by WR_CLR, because only bits in mask are written.

Reset
REQ-029 While reset=1: state IDLE, timer = POLL_PERIOD-1, mask = 0, button_level = 0, event_count = 0, event_pulse = 0, busy = 0, and all avm_* outputs 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transfer immediately; after release, polling restarts with a full POLL_PERIOD wait.

Verification
REQ-031 POLL_PERIOD=8, enable=1, slave edge reg=0, waitrequest=0 -> read at 0xC every 8 cycles, no write, event_pulse=0, event_count=0.
REQ-032 Edge reg=0b10 -> write 0x00000002 to 0xC, then read 0x0, then one-cycle event_pulse=0b10, event_count=1.
REQ-033 Edge reg=0b11, waitrequest held 3 cycles on each transfer -> signals held stable, event_pulse=0b11, event_count increments by 2.
REQ-034 event_count=0xFFFF, mask=0b01 -> event_count=0x0000 after REPORT.
REQ-035 Reset asserted during WR_CLR with waitrequest=1 -> avm_write drops in the same cycle, all outputs reset, and the next read begins POLL_PERIOD cycles after release.
REQ-036 enable deasserted during RD_DATA -> transaction completes, REPORT occurs, and no further reads are issued until enable=1.
